// File: rtl/if_pc_unit_if.sv
// Bundle of fetch-stage signals between the PC/IF-ID unit and its neighbours
// (fetch adder, imem, hazard unit, EX redirect).
interface if_pc_unit_if #(
   parameter int N = 32
);
   logic [N-1:0] pc_plus4_i;
   logic         branch_taken_i;
   logic [N-1:0] branch_target_i;
   logic         stall_i;
   logic         halt_i;
   logic [N-1:0] instr_i;
   logic [N-1:0] pc_o;
   logic [N-1:0] ifid_pc_o;
   logic [N-1:0] ifid_instr_o;
   logic         ifid_valid_o;
   logic         halted_o;
   logic         misalign_o;
   logic [1:0]   state_dbg;

   // The unit owns the *_o side.
   modport slave (
      input  pc_plus4_i, branch_taken_i, branch_target_i, stall_i, halt_i, instr_i,
      output pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o, misalign_o, state_dbg
   );

   // The environment drives the *_i side.
   modport master (
      output pc_plus4_i, branch_taken_i, branch_target_i, stall_i, halt_i, instr_i,
      input  pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o, misalign_o, state_dbg
   );
endinterface

// File: rtl/if_pc_unit.sv
// PC register and IF/ID pipeline register with BOOT/RUN/HALT control.
// Optional macro IF_MISALIGN_TRAP_EN: a misaligned redirect traps into HALT.
module if_pc_unit #(
   parameter int           N         = 32,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter logic [N-1:0] NOP_INSTR = 32'h0000_0000
) (
   input logic clk,
   input logic rst_n,
   if_pc_unit_if.slave bus
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] ifid_pc_q, ifid_pc_d;
   logic [N-1:0] ifid_instr_q, ifid_instr_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic         halted_q, halted_d;
   logic         misalign_q, misalign_d;

   // IF/ID handshake: ifid_valid_o marks a real instruction; there is no ready,
   // stall_i is the back-pressure and freezes both PC and IF/ID while asserted.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      halted_d     = halted_q;
      misalign_d   = misalign_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (bus.halt_i) begin
               state_d      = HALT;
               halted_d     = 1'b1;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (bus.branch_taken_i) begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
               if (bus.branch_target_i[1:0] != 2'b00) begin
                  state_d    = HALT;
                  halted_d   = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  pc_d = bus.branch_target_i;
               end
`else
               pc_d = bus.branch_target_i;
`endif
            end else if (!bus.stall_i) begin
               pc_d         = bus.pc_plus4_i;
               ifid_pc_d    = pc_q;
               ifid_instr_d = bus.instr_i;
               ifid_valid_d = 1'b1;
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         halted_q     <= halted_d;
         misalign_q   <= misalign_d;
      end
   end

   assign bus.pc_o         = pc_q;
   assign bus.ifid_pc_o    = ifid_pc_q;
   assign bus.ifid_instr_o = ifid_instr_q;
   assign bus.ifid_valid_o = ifid_valid_q;
   assign bus.halted_o     = halted_q;
   assign bus.state_dbg    = state_q;
`ifdef IF_MISALIGN_TRAP_EN
   assign bus.misalign_o   = misalign_q;
`else
   // Flag is never set without the trap; keep it tied off at the port.
   assign bus.misalign_o   = 1'b0;
`endif

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
Program-counter and IF/ID boundary for the fetch stage of the RSA-decryption ASIP.
- Holds the architectural PC and drives it to the instruction memory and to the PC+4 adder.
- Selects the next PC from the adder result or a redirect target.
- Registers the fetched instruction and its PC into the IF/ID pipeline register, with valid, stall, flush and halt control.

Parameters:
N, 32, datapath/address width in bits
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pc_plus4_i  input  N  PC+4 from fetch adder (computed from pc_o)
branch_taken_i  input  1  redirect request from EX
branch_target_i  input  N  redirect target address
stall_i  input  1  hold request from hazard unit
halt_i  input  1  halt request (end of program)
instr_i  input  N  instruction word read combinationally from imem at pc_o
pc_o  output  N  current PC (to imem address and adder operand a)
ifid_pc_o  output  N  PC of instruction held in IF/ID
ifid_instr_o  output  N  instruction held in IF/ID
ifid_valid_o  output  1  IF/ID contents are a real instruction
halted_o  output  1  unit is in HALT state
misalign_o  output  1  misaligned redirect detected (see optional feature)

Behaviour:
- Reset (rst_n low, asynchronous, immediate, also mid-operation):
  - pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, halted_o=0, misalign_o=0.
  - State enters BOOT.
- State machine: BOOT, RUN, HALT (2-bit encoding).
  - BOOT: exactly one cycle after rst_n rises. PC held; IF/ID unchanged (valid 0); redirect/stall/halt inputs ignored. Next state is RUN.
  - RUN: evaluate controls each rising edge in this priority: halt_i > branch_taken_i > stall_i > advance.
    - halt_i=1: next state HALT. PC held. ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR.
    - branch_taken_i=1: pc_o<=branch_target_i. ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR (wrong-path flush). A branch overrides a simultaneous stall.
    - stall_i=1: pc_o and all IF/ID registers hold their values.
    - advance: pc_o<=pc_plus4_i; ifid_pc_o<=pc_o; ifid_instr_o<=instr_i; ifid_valid_o<=1.
  - HALT: sticky until reset. All registers hold; ifid_valid_o stays 0; halted_o=1 (registered, asserted the cycle after halt_i is sampled).
- Latency:
  - Instruction fetched at PC p appears on ifid_* one cycle after the advance edge.
  - After a redirect, the first valid target instruction appears two edges later.
- Arithmetic/width:
  - pc_plus4_i is accepted verbatim; wrap-around at 2^N is the adder's modulo result, and the unit does not check for it.
  - All registers are N bits; no sign extension.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
Macro IF_MISALIGN_TRAP_EN.
- Defined: a RUN-state redirect with branch_target_i[1:0]!=0 does not load the PC. Instead the unit sets misalign_o<=1 (sticky until reset), flushes IF/ID (valid 0, NOP), and enters HALT. Aligned targets behave as normal.
- Not defined: targets are loaded verbatim regardless of alignment, and misalign_o is tied to 0.

Test Plan:
- Reset release with RESET_PC=0, instr_i=addr-based pattern, no controls: BOOT cycle keeps pc_o=0 and valid=0, then pc_o steps 0,4,8,C. ifid_pc_o lags pc_o by one cycle, with valid=1 from the second RUN edge.
- pc_o=0x10, stall_i=1 for 3 cycles, then release: pc_o and ifid_* frozen at 0x10 / previous values for 3 cycles, then resume 0x14.
- pc_o=0x20, branch_taken_i=1 and stall_i=1 simultaneously, target 0x100: pc_o=0x100, ifid_valid_o=0, ifid_instr_o=NOP. Next edge ifid_pc_o=0x100 with valid=1.
- halt_i=1 at pc 0x40 together with branch_taken_i=1: pc_o stays 0x40, halted_o=1 the next cycle, valid=0. Later stall/branch pulses cause no change until rst_n drops.
- rst_n pulled low mid-run at pc 0x1C, asynchronous to clk: all outputs reach their reset values before the next edge, and the BOOT sequence repeats.
- IF_MISALIGN_TRAP_EN defined, branch target 0x102: misalign_o=1, halted_o=1, pc_o unchanged. Without the macro: pc_o=0x102 and misalign_o=0.
